// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU: operation codes
//               and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Operation codes; 13..15 are undefined and complete with a zero result.
    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_NOT  = 4'd2;
    localparam logic [3:0] c_OP_NEG  = 4'd3;
    localparam logic [3:0] c_OP_ADD  = 4'd4;
    localparam logic [3:0] c_OP_SUB  = 4'd5;
    localparam logic [3:0] c_OP_MUL  = 4'd6;
    localparam logic [3:0] c_OP_DIV  = 4'd7;
    localparam logic [3:0] c_OP_SHR  = 4'd8;
    localparam logic [3:0] c_OP_SHRA = 4'd9;
    localparam logic [3:0] c_OP_SHL  = 4'd10;
    localparam logic [3:0] c_OP_ROR  = 4'd11;
    localparam logic [3:0] c_OP_ROL  = 4'd12;

    // Controller states.
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_MUL      = 3'd1;
    localparam state_t c_ST_DIV      = 3'd2;
    localparam state_t c_ST_DIV_CORR = 3'd3;
    localparam state_t c_ST_DONE     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/alu_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_shifter
// Description : Combinational shift/rotate unit for SHR, SHRA, SHL, ROR, ROL.
//               Any other op code yields zero.
// Ports       : i_a   - source operand
//               i_amt - shift/rotate amount
//               i_op  - operation code
//               o_y   - shifted/rotated result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_amt,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    // Complementary amount for the wrap-around half of a rotate. A rotate by
    // zero shifts the wrap half by WIDTH, which yields zero, so a passes through.
    logic [SHW:0] w_inv_amt;

    always_comb begin
        w_inv_amt = (SHW+1)'(WIDTH) - {1'b0, i_amt};
        o_y       = '0;
        case (i_op)
            c_OP_SHR:  o_y = i_a >> i_amt;
            c_OP_SHRA: o_y = $unsigned($signed(i_a) >>> i_amt);
            c_OP_SHL:  o_y = i_a << i_amt;
            c_OP_ROR:  o_y = (i_a >> i_amt) | (i_a << w_inv_amt);
            c_OP_ROL:  o_y = (i_a << i_amt) | (i_a >> w_inv_amt);
            default:   o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU. Logic/shift/add ops finish in one cycle,
//               signed multiply uses iterative Booth recoding, signed divide
//               uses iterative non-restoring division. Result is {hi, lo}.
//               Build option ALU_SEQ_RADIX4_EN selects radix-4 Booth
//               (WIDTH/2 multiply steps) instead of radix-2 (WIDTH steps).
// Ports       : clock    - rising-edge clock
//               clear    - synchronous active-high reset
//               start    - begin operation (sampled while ready)
//               op       - operation code
//               a, b     - operands
//               ready    - idle, accepting start
//               done     - one-cycle completion pulse
//               result   - {hi, lo}
//               div_zero - last DIV had a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero
);

`ifdef ALU_SEQ_RADIX4_EN
    localparam int c_MUL_STEPS = WIDTH / 2;
`else
    localparam int c_MUL_STEPS = WIDTH;
`endif
    localparam int             c_CW       = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_MUL_LAST = c_CW'(c_MUL_STEPS - 1);
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(WIDTH - 1);

    state_t r_state, w_state_nxt;

    // Shared datapath: r_acc is the Booth accumulator or the partial
    // remainder, r_mq the multiplier or the dividend/quotient, r_mcand the
    // multiplicand or the divisor magnitude. Two guard bits on r_acc absorb
    // the +/-2M Booth digits and the shifted remainder.
    logic [WIDTH+1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_qm1;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_div_zero;

    logic [WIDTH-1:0]          w_shift_y;
    logic [WIDTH-1:0]          w_single;
    logic [WIDTH-1:0]          w_a_mag;
    logic [WIDTH-1:0]          w_b_mag;
    logic                      w_b_zero;
    logic [WIDTH+1:0]          w_m_ext;
    logic [WIDTH+1:0]          w_booth_add;
    logic [WIDTH+1:0]          w_booth_sum;
    logic signed [2*WIDTH+2:0] w_booth_cat;
    logic signed [2*WIDTH+2:0] w_booth_sh;
    logic [WIDTH+1:0]          w_div_shift;
    logic [WIDTH+1:0]          w_d_ext;
    logic [WIDTH+1:0]          w_div_r;
    logic [WIDTH-1:0]          w_rem_mag;
    logic [WIDTH-1:0]          w_quo_out;
    logic [WIDTH-1:0]          w_rem_out;

    alu_seq_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .i_a   (a),
        .i_amt (b[SHW-1:0]),
        .i_op  (op),
        .o_y   (w_shift_y)
    );

    // Single-cycle results and operand preparation at acceptance.
    always_comb begin
        w_a_mag  = a[WIDTH-1] ? -a : a;
        w_b_mag  = b[WIDTH-1] ? -b : b;
        w_b_zero = (b == '0);
        w_single = '0;
        case (op)
            c_OP_AND: w_single = a & b;
            c_OP_OR:  w_single = a | b;
            c_OP_NOT: w_single = ~a;
            c_OP_NEG: w_single = -a;
            c_OP_ADD: w_single = a + b;
            c_OP_SUB: w_single = a - b;
            c_OP_SHR, c_OP_SHRA, c_OP_SHL, c_OP_ROR, c_OP_ROL:
                      w_single = w_shift_y;
            default:  w_single = '0;
        endcase
    end

    // Booth step: add the recoded digit times M, then arithmetic shift of
    // {acc, multiplier, q-1} by the number of multiplier bits consumed.
    always_comb begin
        w_m_ext     = {{2{r_mcand[WIDTH-1]}}, r_mcand};
        w_booth_add = '0;
`ifdef ALU_SEQ_RADIX4_EN
        case ({r_mq[1:0], r_qm1})
            3'b001, 3'b010: w_booth_add = w_m_ext;
            3'b011:         w_booth_add = w_m_ext << 1;
            3'b100:         w_booth_add = -(w_m_ext << 1);
            3'b101, 3'b110: w_booth_add = -w_m_ext;
            default:        w_booth_add = '0;
        endcase
        w_booth_sum = r_acc + w_booth_add;
        w_booth_cat = {w_booth_sum, r_mq, r_qm1};
        w_booth_sh  = w_booth_cat >>> 2;
`else
        case ({r_mq[0], r_qm1})
            2'b01:   w_booth_add = w_m_ext;
            2'b10:   w_booth_add = -w_m_ext;
            default: w_booth_add = '0;
        endcase
        w_booth_sum = r_acc + w_booth_add;
        w_booth_cat = {w_booth_sum, r_mq, r_qm1};
        w_booth_sh  = w_booth_cat >>> 1;
`endif
    end

    // Non-restoring step on magnitudes. The partial remainder stays within
    // [-D, D), so its top guard bit can be dropped before the left shift.
    always_comb begin
        w_d_ext     = {2'b00, r_mcand};
        w_div_shift = {r_acc[WIDTH:0], r_mq[WIDTH-1]};
        w_div_r     = r_acc[WIDTH+1] ? (w_div_shift + w_d_ext)
                                     : (w_div_shift - w_d_ext);
        // Final remainder fits WIDTH bits once corrected into [0, D).
        w_rem_mag   = r_acc[WIDTH+1] ? (r_acc[WIDTH-1:0] + r_mcand)
                                     : r_acc[WIDTH-1:0];
        w_quo_out   = (r_a_neg ^ r_b_neg) ? -r_mq : r_mq;
        w_rem_out   = r_a_neg ? -w_rem_mag : w_rem_mag;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    case (op)
                        c_OP_MUL: w_state_nxt = c_ST_MUL;
                        c_OP_DIV: w_state_nxt = w_b_zero ? c_ST_DONE : c_ST_DIV;
                        default:  w_state_nxt = c_ST_DONE;
                    endcase
                end
            end
            c_ST_MUL: begin
                if (r_cnt == c_MUL_LAST) w_state_nxt = c_ST_DONE;
            end
            c_ST_DIV: begin
                if (r_cnt == c_DIV_LAST) w_state_nxt = c_ST_DIV_CORR;
            end
            c_ST_DIV_CORR: w_state_nxt = c_ST_DONE;
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_acc      <= '0;
            r_mq       <= '0;
            r_mcand    <= '0;
            r_qm1      <= 1'b0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_a_neg <= a[WIDTH-1];
                        r_b_neg <= b[WIDTH-1];
                        case (op)
                            c_OP_MUL: begin
                                r_mcand <= a;
                                r_mq    <= b;
                            end
                            c_OP_DIV: begin
                                r_mcand <= w_b_mag;
                                r_mq    <= w_a_mag;
                                if (w_b_zero) begin
                                    r_result   <= {a, {WIDTH{1'b1}}};
                                    r_div_zero <= 1'b1;
                                end
                            end
                            default: begin
                                r_result   <= {{WIDTH{1'b0}}, w_single};
                                r_div_zero <= 1'b0;
                            end
                        endcase
                    end
                end
                c_ST_MUL: begin
                    r_acc <= w_booth_sh[2*WIDTH+2:WIDTH+1];
                    r_mq  <= w_booth_sh[WIDTH:1];
                    r_qm1 <= w_booth_sh[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_MUL_LAST) begin
                        r_result   <= w_booth_sh[2*WIDTH:1];
                        r_div_zero <= 1'b0;
                    end
                end
                c_ST_DIV: begin
                    r_acc <= w_div_r;
                    r_mq  <= {r_mq[WIDTH-2:0], ~w_div_r[WIDTH+1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                c_ST_DIV_CORR: begin
                    r_result   <= {w_rem_out, w_quo_out};
                    r_div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=32). Expected results
//               come from a behavioural model and are queued at stimulus
//               time, then popped when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int c_W       = 32;
    localparam int c_TIMEOUT = 200;
`ifdef ALU_SEQ_RADIX4_EN
    localparam int c_MUL_LAT = c_W / 2 + 1;
`else
    localparam int c_MUL_LAT = c_W + 1;
`endif
    localparam int c_DIV_LAT = c_W + 2;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic            clock;
    logic            clear;
    logic            start;
    logic [3:0]      op;
    logic [c_W-1:0]  a;
    logic [c_W-1:0]  b;
    logic            ready;
    logic            done;
    logic [2*c_W-1:0] result;
    logic            div_zero;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    alu_seq #(
        .WIDTH (c_W)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t               e;
        logic [31:0]        lo;
        logic [4:0]         s;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] r;
        e.dz  = 1'b0;
        e.lat = 1;
        lo    = '0;
        s     = y[4:0];
        sx    = {{32{x[31]}}, x};
        sy    = {{32{y[31]}}, y};
        case (o)
            4'd0:  lo = x & y;
            4'd1:  lo = x | y;
            4'd2:  lo = ~x;
            4'd3:  lo = -x;
            4'd4:  lo = x + y;
            4'd5:  lo = x - y;
            4'd8:  lo = x >> s;
            4'd9:  lo = $signed(x) >>> s;
            4'd10: lo = x << s;
            4'd11: begin
                lo = x;
                for (int i = 0; i < int'(s); i++) lo = {lo[0], lo[31:1]};
            end
            4'd12: begin
                lo = x;
                for (int i = 0; i < int'(s); i++) lo = {lo[30:0], lo[31]};
            end
            default: lo = '0;
        endcase
        e.res = {32'h0, lo};
        if (o == 4'd6) begin
            e.res = sx * sy;
            e.lat = c_MUL_LAT;
        end else if (o == 4'd7) begin
            if (y == 32'h0) begin
                e.res = {x, 32'hFFFF_FFFF};
                e.dz  = 1'b1;
            end else begin
                q     = sx / sy;
                r     = sx % sy;
                e.res = {r[31:0], q[31:0]};
                e.lat = c_DIV_LAT;
            end
        end
        return e;
    endfunction

    // Issue one operation, optionally poke start mid-flight, and score it.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit mid_start);
        exp_t e;
        int   lat;
        @(negedge clock);
        chk("ready_before", {63'h0, ready}, 64'h1);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clock);
        #1;
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        a     = $urandom;
        b     = $urandom;
        op    = 4'd4;
        chk("ready_falls", {63'h0, ready}, 64'h0);
        lat = 1;
        while (!done && lat < c_TIMEOUT) begin
            start = (mid_start && lat == 3);
            @(posedge clock);
            #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
        chk("latency", 64'(lat), 64'(e.lat));
        @(posedge clock);
        #1;
        chk("ready_back", {63'h0, ready}, 64'h1);
        chk("done_pulse", {63'h0, done}, 64'h0);
    endtask

    initial begin
        int n_done;
        n_checks = 0;
        n_pass   = 0;
        clear    = 1'b1;
        start    = 1'b0;
        op       = 4'd0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", {63'h0, ready}, 64'h1);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_result", result, 64'h0);
        chk("rst_dz", {63'h0, div_zero}, 64'h0);
        clear = 1'b0;

        do_op(4'd4, 32'd7, 32'd5, 1'b0);
        chk("add_7_5", result, 64'h0000_0000_0000_000C);
        do_op(4'd6, 32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("mul_m3_7", result, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(4'd7, 32'hFFFF_FFEF, 32'd5, 1'b0);
        chk("div_m17_5", result, 64'hFFFF_FFFE_FFFF_FFFD);
        do_op(4'd7, 32'd9, 32'd0, 1'b0);
        chk("div0_flag", {63'h0, div_zero}, 64'h1);
        chk("div0_res", result, 64'h0000_0009_FFFF_FFFF);
        do_op(4'd4, 32'd1, 32'd2, 1'b0);
        chk("div0_cleared", {63'h0, div_zero}, 64'h0);
        do_op(4'd12, 32'h8000_0001, 32'd4, 1'b0);
        chk("rol_4", result, 64'h0000_0000_0000_0018);
        do_op(4'd11, 32'h1234_5678, 32'd0, 1'b0);
        chk("ror_0", result, 64'h0000_0000_1234_5678);
        do_op(4'd9, 32'h8000_0000, 32'd33, 1'b0);
        chk("shra_33", result, 64'h0000_0000_C000_0000);
        do_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_min_m1", result, 64'h0000_0000_8000_0000);
        do_op(4'd6, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(4'd14, 32'hFFFF_FFFF, 32'h1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            do_op(4'(i), $urandom, $urandom, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            do_op(4'd6, $urandom, $urandom, 1'b0);
            do_op(4'd7, $urandom, $urandom_range(1, 1000), 1'b0);
        end

        // Abort a multiply with clear.
        @(negedge clock);
        op    = 4'd6;
        a     = 32'd5;
        b     = 32'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("abort_ready", {63'h0, ready}, 64'h1);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_result", result, 64'h0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'h0);
        do_op(4'd6, 32'd2, 32'd3, 1'b0);
        chk("mul_2_3", result, 64'h6);

        // clear and start together: start is dropped.
        @(negedge clock);
        clear = 1'b1;
        start = 1'b1;
        op    = 4'd4;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        start = 1'b0;
        chk("clr_start_ready", {63'h0, ready}, 64'h1);
        @(posedge clock);
        #1;
        chk("clr_start_done", {63'h0, done}, 64'h0);
        chk("clr_start_res", result, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
